// File: rtl/miriscv_data_xbar.sv
// Data-side bus decoder for the miriscv LSU: address decode to power-of-two slave regions,
// req/gnt forwarding, response routing, unmapped/timeout error responses and an error counter.
//
// state    | meaning
// ST_IDLE  | no transaction outstanding; decode and forward the core request
// ST_WAIT  | granted by slave r_sel, waiting for its rvalid or the timeout
// ST_ERR   | unmapped access accepted; emit the error response
module miriscv_data_xbar #(
  parameter int                            NUM_SLAVES      = 2,
  parameter int                            ADDR_W          = 32,
  parameter int                            DATA_W          = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]  SLAVE_BASE      = {32'h1000, 32'h0},
  parameter logic [NUM_SLAVES*8-1:0]       SLAVE_SIZE_LOG2 = {8'd12, 8'd8},
  parameter int                            TIMEOUT         = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          core_req_i,
  input  logic                          core_we_i,
  input  logic [DATA_W/8-1:0]           core_be_i,
  input  logic [ADDR_W-1:0]             core_addr_i,
  input  logic [DATA_W-1:0]             core_wdata_i,
  output logic                          core_gnt_o,
  output logic                          core_rvalid_o,
  output logic [DATA_W-1:0]             core_rdata_o,
  output logic                          core_err_o,
  output logic [15:0]                   err_cnt_o,
  output logic [NUM_SLAVES-1:0]         s_req_o,
  output logic                          s_we_o,
  output logic [DATA_W/8-1:0]           s_be_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  input  logic [NUM_SLAVES-1:0]         s_gnt_i,
  input  logic [NUM_SLAVES-1:0]         s_rvalid_i,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata_i
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR} state_t;

  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt, w_sel;
  logic [TW-1:0]     r_timer, w_timer_nxt;
  logic [15:0]       r_err_cnt;
  logic              w_any_hit;
  logic [NUM_SLAVES-1:0] w_hit;
  logic [7:0]        w_size [NUM_SLAVES];
  logic [DATA_W-1:0] w_rdata [NUM_SLAVES];
  logic [ADDR_W-1:0] w_mask;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_dec
    assign w_size[g]  = SLAVE_SIZE_LOG2[g*8 +: 8];
    assign w_rdata[g] = s_rdata_i[g*DATA_W +: DATA_W];
    assign w_hit[g]   = (core_addr_i >> w_size[g]) ==
                        (SLAVE_BASE[g*ADDR_W +: ADDR_W] >> w_size[g]);
  end

  // Scan from the top so the lowest matching index ends up selected.
  always_comb begin
    w_sel     = '0;
    w_any_hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel     = SEL_W'(i);
        w_any_hit = 1'b1;
      end
    end
  end

  assign w_mask    = ~({ADDR_W{1'b1}} << w_size[w_sel]);
  assign s_addr_o  = core_addr_i & w_mask;
  assign s_we_o    = core_we_i;
  assign s_be_o    = core_be_i;
  assign s_wdata_o = core_wdata_i;
  assign err_cnt_o = r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_timer   <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_timer <= w_timer_nxt;
      if (core_rvalid_o && core_err_o && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_timer_nxt   = r_timer;
    s_req_o       = '0;
    core_gnt_o    = 1'b0;
    core_rvalid_o = 1'b0;
    core_rdata_o  = '0;
    core_err_o    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (core_req_i) begin
          if (w_any_hit) begin
            s_req_o    = NUM_SLAVES'(1) << w_sel;
            core_gnt_o = s_gnt_i[w_sel];
            if (s_gnt_i[w_sel]) begin
              w_sel_nxt   = w_sel;
              w_timer_nxt = '0;
              w_state_nxt = ST_WAIT;
            end
          end else begin
            core_gnt_o  = 1'b1;
            w_state_nxt = ST_ERR;
          end
        end
      end
      ST_WAIT: begin
        w_timer_nxt = r_timer + TW'(1);
        if (s_rvalid_i[r_sel]) begin
          core_rvalid_o = 1'b1;
          core_rdata_o  = w_rdata[r_sel];
          w_state_nxt   = ST_IDLE;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          core_rvalid_o = 1'b1;
          core_err_o    = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_ERR: begin
        core_rvalid_o = 1'b1;
        core_err_o    = 1'b1;
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_miriscv_data_xbar.sv
// Bench for miriscv_data_xbar: directed scenarios then random transactions, checked against
// a region-arithmetic reference model.
module tb_miriscv_data_xbar;
  localparam int TO = 16;
  localparam logic [63:0] BASE = {32'h1000, 32'h0};
  localparam logic [15:0] SZL2 = {8'd12, 8'd8};

  logic        clk, rst;
  logic        core_req, core_we, core_gnt, core_rvalid, core_err;
  logic [3:0]  core_be, s_be;
  logic [31:0] core_addr, core_wdata, core_rdata, s_addr, s_wdata;
  logic [15:0] err_cnt;
  logic [1:0]  s_req, s_gnt, s_rvalid;
  logic        s_we;
  logic [63:0] s_rdata;

  int n_pass = 0, n_total = 0, n_fail = 0, exp_cnt = 0;

  miriscv_data_xbar dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .core_err_o(core_err), .err_cnt_o(err_cnt),
    .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Region membership by plain range arithmetic; first listed region wins.
  function automatic int ref_sel(input logic [31:0] a);
    for (int i = 0; i < 2; i++) begin
      longint unsigned b  = longint'(BASE[i*32 +: 32]);
      longint unsigned sz = 64'd1 << SZL2[i*8 +: 8];
      if (longint'(a) >= b && longint'(a) < b + sz) return i;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
    s_gnt = 0; s_rvalid = 0; s_rdata = 0;
  endtask

  task automatic txn(input logic [31:0] a, input logic we, input logic [3:0] be,
                     input logic [31:0] wd, input int gdly, input int rdly,
                     input bit norsp, input logic [31:0] rd, input bit late);
    int sel;
    logic [31:0] off;
    logic [1:0] oh;
    bit rv;
    sel = ref_sel(a);
    off = '0;
    oh  = '0;
    if (sel >= 0) begin
      off = a - BASE[sel*32 +: 32];
      oh  = 2'b01 << sel;
    end
    for (int k = 0; k <= ((sel < 0) ? 0 : gdly); k++) begin
      step();
      core_req = 1; core_we = we; core_be = be; core_addr = a; core_wdata = wd;
      s_rvalid = 0;
      s_gnt = (sel >= 0 && k == gdly) ? oh : 2'b00;
      #1;
      chk("idle_rvalid", core_rvalid, 0);
      if (sel >= 0) begin
        chk("s_req", s_req, oh);
        chk("s_addr", s_addr, off);
        chk("s_we", s_we, we);
        chk("s_be", s_be, be);
        chk("s_wdata", s_wdata, wd);
        chk("gnt", core_gnt, (k == gdly));
      end else begin
        chk("unmapped_gnt", core_gnt, 1);
        chk("unmapped_s_req", s_req, 0);
      end
    end
    if (sel < 0) begin
      step();
      s_gnt = 0;
      #1;
      chk("err_rvalid", core_rvalid, 1);
      chk("err_err", core_err, 1);
      chk("err_rdata", core_rdata, 0);
      chk("err_gnt_blocked", core_gnt, 0);
      exp_cnt++;
    end else begin
      for (int w = 0; w < TO; w++) begin
        step();
        core_req = 1'($urandom);
        s_gnt    = 2'($urandom);
        s_rdata  = {$urandom, $urandom};
        rv = (!norsp && w == rdly) || (norsp && w == TO - 1);
        if (!norsp && w == rdly) begin
          s_rvalid = oh;
          s_rdata[sel*32 +: 32] = rd;
        end else begin
          s_rvalid = ~oh & 2'($urandom);
        end
        #1;
        chk("wait_s_req", s_req, 0);
        chk("wait_gnt", core_gnt, 0);
        chk("wait_rvalid", core_rvalid, rv);
        if (rv) begin
          chk("rsp_err", core_err, norsp);
          chk("rsp_rdata", core_rdata, norsp ? 32'h0 : rd);
          if (norsp) exp_cnt++;
          break;
        end
      end
    end
    step();
    clear_inputs();
    if (late) s_rvalid = oh;
    #1;
    chk("after_rvalid", core_rvalid, 0);
    chk("err_cnt", err_cnt, exp_cnt);
    s_rvalid = 0;
  endtask

  initial begin
    int cls;
    logic [31:0] a;
    clear_inputs();
    rst = 1;
    step();
    step();
    chk("rst_s_req", s_req, 0);
    chk("rst_gnt", core_gnt, 0);
    chk("rst_rvalid", core_rvalid, 0);
    chk("rst_err", core_err, 0);
    chk("rst_rdata", core_rdata, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst = 0;

    txn(32'h10,   0, 4'hF, 32'h0,        0, 0, 0, 32'hDEADBEEF, 0);
    txn(32'h1004, 1, 4'hF, 32'hA5A5A5A5, 0, 2, 0, 32'h0,        0);
    txn(32'h0800, 0, 4'hF, 32'h0,        0, 0, 0, 32'h0,        0);
    txn(32'h1000, 0, 4'hF, 32'h0,        0, 0, 1, 32'h0,        1);
    txn(32'h20,   0, 4'h3, 32'h0,        3, 1, 0, 32'h12345678, 0);

    step();
    core_req = 1; core_addr = 32'h10; s_gnt = 2'b01;
    #1;
    chk("rst_pre_gnt", core_gnt, 1);
    step();
    core_req = 0; s_gnt = 0; rst = 1;
    #1;
    chk("rst_in_wait_rvalid", core_rvalid, 0);
    step();
    rst = 0; s_rvalid = 2'b01;
    #1;
    chk("rst_dropped_rvalid", core_rvalid, 0);
    chk("rst_dropped_s_req", s_req, 0);
    chk("rst_cleared_cnt", err_cnt, 0);
    s_rvalid = 0;
    exp_cnt = 0;
    txn(32'h10, 0, 4'hF, 32'h0, 0, 0, 0, 32'hCAFEF00D, 0);

    for (int t = 0; t < 40; t++) begin
      cls = $urandom_range(0, 3);
      case (cls)
        0: a = $urandom_range(0, 32'hFF);
        1: a = 32'h1000 + $urandom_range(0, 32'hFFF);
        2: a = $urandom_range(32'h100, 32'hFFF);
        default: a = $urandom;
      endcase
      txn(a, 1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 3),
          $urandom_range(0, 4), ($urandom_range(0, 7) == 0), $urandom, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
